counter_using_tff: RTL and testbench



---
 rtl/counter_using_tff_pkg.sv | 10 +
 rtl/counter_using_tff_tff.sv | 28 ++
 rtl/counter_using_tff.sv | 47 ++++
 tb/tb_counter_using_tff.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/counter_using_tff_pkg.sv
// Shared constants for the T flip-flop based counter.
//
// Contents:
//   DEFAULT_COUNTER_WIDTH - default bit width of the counter output Q.
`timescale 1ns/1ps
package counter_using_tff_pkg;

    localparam int DEFAULT_COUNTER_WIDTH = 8;

endpackage : counter_using_tff_pkg

// File: rtl/counter_using_tff_tff.sv
// Single T flip-flop cell with synchronous active-high reset.
//
// Ports:
//   clk - system clock, state updates on the rising edge
//   rst - synchronous active-high reset, forces q to 0
//   t   - toggle enable: q inverts on the next edge when t=1
//   q   - registered flip-flop output
`timescale 1ns/1ps
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    logic q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= 1'b0;
        end else begin
            q_reg <= q_reg ^ t;
        end
    end

    assign q = q_reg;

endmodule : tff_cell

// File: rtl/counter_using_tff.sv
// Free-running synchronous binary up-counter built from a chain of T
// flip-flops. Every cell shares clk; a cell toggles when all lower bits are
// 1, which is exactly the carry condition of a +1 increment.
//
// Parameters:
//   WIDTH - number of counter bits (>= 1)
//
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset, clears Q on the sampling edge
//   Q   - current count, taken straight from the flip-flop outputs
`timescale 1ns/1ps
module counter_using_tff
    import counter_using_tff_pkg::*;
#(
    parameter int WIDTH = DEFAULT_COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] Q
);

    // t_chain[i] is the prefix AND of Q[i-1:0]; bit 0 always toggles.
    logic [WIDTH-1:0] t_chain;
    logic [WIDTH-1:0] q_bits;

    assign t_chain[0] = 1'b1;

    generate
        genvar gi;
        for (gi = 1; gi < WIDTH; gi++) begin : g_t_chain
            assign t_chain[gi] = t_chain[gi-1] & q_bits[gi-1];
        end

        for (gi = 0; gi < WIDTH; gi++) begin : g_cells
            tff_cell u_cell (
                .clk (clk),
                .rst (rst),
                .t   (t_chain[gi]),
                .q   (q_bits[gi])
            );
        end
    endgenerate

    assign Q = q_bits;

endmodule : counter_using_tff

// File: tb/tb_counter_using_tff.sv
// Bench for counter_using_tff: an 8-bit and a 4-bit instance share clk/rst.
// A reference count (plain modular arithmetic) is compared against both on
// every falling edge once a reset has been seen; directed phases add
// hand-computed literal expectations, then random reset pulses follow.
`timescale 1ns/1ps
module tb_counter_using_tff;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] q8;
    logic [3:0] q4;

    int checks = 0;
    int fails  = 0;

    int model8 = 0;
    int model4 = 0;
    bit model_valid = 1'b0;

    always #1.8 clk = ~clk;

    counter_using_tff #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .Q   (q8)
    );

    counter_using_tff #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .Q   (q4)
    );

    // Reference: reset clears, otherwise count up modulo 2^WIDTH.
    always @(posedge clk) begin
        if (rst) begin
            model8      <= 0;
            model4      <= 0;
            model_valid <= 1'b1;
        end else begin
            model8 <= (model8 + 1) % 256;
            model4 <= (model4 + 1) % 16;
        end
    end

    // Continuous comparison, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (int'(q8) != model8) begin
                fails++;
                $display("FAIL model_q8 t=%0t got=0x%02h expected=0x%02h", $time, q8, model8[7:0]);
            end
            checks++;
            if (int'(q4) != model4) begin
                fails++;
                $display("FAIL model_q4 t=%0t got=0x%01h expected=0x%01h", $time, q4, model4[3:0]);
            end
        end
    end

    task automatic check_lit(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end else begin
            $display("check %s value=0x%0h ok", name, got);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One reset edge, leaves Q at 0 sampled on the following falling edge.
    task automatic do_reset();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    initial begin
        // Reset release and first increments.
        cyc(1);
        check_lit("reset_q8", int'(q8), 0);
        check_lit("reset_q4", int'(q4), 0);
        rst = 1'b0;
        cyc(1); check_lit("first_1", int'(q8), 1);
        cyc(1); check_lit("first_2", int'(q8), 2);
        cyc(1); check_lit("first_3", int'(q8), 3);

        // Carry propagation.
        do_reset();
        cyc(15);  check_lit("carry_0f", int'(q8), 8'h0F);
        check_lit("carry_q4_15", int'(q4), 15);
        cyc(112); check_lit("carry_7f", int'(q8), 8'h7F);
        cyc(1);   check_lit("carry_80", int'(q8), 8'h80);

        // Wrap-around (255 edges from reset in total).
        cyc(127); check_lit("wrap_ff", int'(q8), 8'hFF);
        check_lit("wrap_q4_f", int'(q4), 4'hF);
        cyc(1);   check_lit("wrap_00", int'(q8), 0);
        check_lit("wrap_q4_0", int'(q4), 0);
        cyc(1);   check_lit("wrap_01", int'(q8), 1);

        // Reset in the middle of a count.
        do_reset();
        cyc(90);  check_lit("mid_5a", int'(q8), 8'h5A);
        rst = 1'b1;
        cyc(1);   check_lit("mid_rst_00", int'(q8), 0);
        rst = 1'b0;
        cyc(1);   check_lit("mid_after_01", int'(q8), 1);

        // Reset held across the all-ones wrap.
        do_reset();
        cyc(255); check_lit("hold_ff", int'(q8), 8'hFF);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1); check_lit($sformatf("hold_rst_%0d", i), int'(q8), 0);
        end
        rst = 1'b0;
        cyc(1);   check_lit("hold_after_01", int'(q8), 1);

        // 4-bit instance: full sequence then wrap.
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            rst = 1'b0;
            check_lit($sformatf("w4_seq_%0d", i), int'(q4), i);
        end
        cyc(1); check_lit("w4_wrap_0", int'(q4), 0);

        // Random reset pulses; the continuous compare does the checking.
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_counter_using_tff
